// File: rtl/vga_draw_scheduler_pkg.sv
// rtl/vga_draw_scheduler_pkg.sv - shared types and constants for the VGA draw scheduler
// Purpose: FSM state encoding, requester count, coordinate/size/colour widths and the
//          visible screen limits used for clipping.
// Ports:   none (package).
package vga_draw_scheduler_pkg;

  localparam int NREQ    = 3;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int DW      = 4;
  localparam int CW      = 3;
  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vga_draw_scheduler_if.sv
// rtl/vga_draw_scheduler_if.sv - requester and pixel-port bundle of the draw scheduler
// Purpose: groups the rectangle request fields, the grant/done handshake and the
//          vga_adapter write port.
// Ports:   master - requester side (drives req and fields, sees grant/done and pixels)
//          slave  - scheduler side (sees req and fields, drives grant/done and pixels)
interface vga_draw_scheduler_if;
  import vga_draw_scheduler_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*YW-1:0] req_y;
  logic [NREQ*DW-1:0] req_w;
  logic [NREQ*DW-1:0] req_h;
  logic [NREQ*CW-1:0] req_colour;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               plot;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour,
    input  grant, done, busy, plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour,
    output grant, done, busy, plot, vga_x, vga_y, vga_colour
  );

endinterface

// File: rtl/vga_draw_scheduler_rr_arbiter.sv
// rtl/vga_draw_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or after the pointer, wrapping.
// Ports:   req   - per-requester request levels
//          ptr   - requester with highest priority this round
//          gnt   - one-hot winner (all zero when nothing requests)
//          valid - at least one request present
module rr_arbiter
  import vga_draw_scheduler_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic [PW-1:0] sel;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sel = PW'((32'(ptr) + k) % NREQ);
      if (!valid && req[sel]) begin
        gnt[sel] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// rtl/vga_draw_scheduler.sv - round-robin rectangle fill scheduler for one vga_adapter port
// Purpose: grants one rectangle request at a time and sweeps it in raster order,
//          one pixel per clock, clipping pixels outside the visible screen.
// Ports:   Clock  - system clock (CLOCK_50)
//          Resetn - synchronous reset, active low
//          bus    - request fields, grant/done handshake, busy, and the pixel write port
module vga_draw_scheduler
  import vga_draw_scheduler_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Resetn,
  vga_draw_scheduler_if.slave  bus
);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] arb_gnt;
  logic            arb_valid;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] done_r;

  logic [XW-1:0]   x_lat;
  logic [YW-1:0]   y_lat;
  logic [DW-1:0]   w_lat;
  logic [DW-1:0]   h_lat;
  logic [CW-1:0]   c_lat;
  logic [DW-1:0]   xc;
  logic [DW-1:0]   yc;

  logic [XW-1:0]   hold_x;
  logic [YW-1:0]   hold_y;
  logic [CW-1:0]   hold_c;

  logic [XW-1:0]   x_in;
  logic [YW-1:0]   y_in;
  logic [DW-1:0]   w_in;
  logic [DW-1:0]   h_in;
  logic [CW-1:0]   c_in;

  logic [XW:0]     sum_x;
  logic [YW:0]     sum_y;
  logic            in_sweep;
  logic            last_col;
  logic            last_row;

  rr_arbiter u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) win_idx = PW'(i);
    end
  end

  // Fields of the requester granted in IDLE, latched during LOAD.
  assign x_in = bus.req_x[sel_idx*XW +: XW];
  assign y_in = bus.req_y[sel_idx*YW +: YW];
  assign w_in = bus.req_w[sel_idx*DW +: DW];
  assign h_in = bus.req_h[sel_idx*DW +: DW];
  assign c_in = bus.req_colour[sel_idx*CW +: CW];

  // One extra bit so a rectangle running off the right/bottom edge is clipped
  // rather than wrapping back onto the screen.
  assign sum_x    = {1'b0, x_lat} + (XW+1)'(xc);
  assign sum_y    = {1'b0, y_lat} + (YW+1)'(yc);
  assign in_sweep = (state == S_SWEEP);
  assign last_col = (xc == w_lat - DW'(1));
  assign last_row = (yc == h_lat - DW'(1));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      sel_idx <= '0;
      grant_r <= '0;
      done_r  <= '0;
      x_lat   <= '0;
      y_lat   <= '0;
      w_lat   <= '0;
      h_lat   <= '0;
      c_lat   <= '0;
      xc      <= '0;
      yc      <= '0;
      hold_x  <= '0;
      hold_y  <= '0;
      hold_c  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            state   <= S_LOAD;
            grant_r <= arb_gnt;
            sel_idx <= win_idx;
            rr_ptr  <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
          end
        end
        S_LOAD: begin
          x_lat <= x_in;
          y_lat <= y_in;
          w_lat <= w_in;
          h_lat <= h_in;
          c_lat <= c_in;
          xc    <= '0;
          yc    <= '0;
          if (w_in != '0 && h_in != '0) begin
            state <= S_SWEEP;
          end else begin
            state  <= S_DONE;
            done_r <= grant_r;
          end
        end
        S_SWEEP: begin
          // Remember the pixel being presented so the port holds it after the sweep.
          hold_x <= sum_x[XW-1:0];
          hold_y <= sum_y[YW-1:0];
          hold_c <= c_lat;
          if (last_col) begin
            xc <= '0;
            if (last_row) begin
              state  <= S_DONE;
              done_r <= grant_r;
            end else begin
              yc <= yc + DW'(1);
            end
          end else begin
            xc <= xc + DW'(1);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          grant_r <= '0;
          done_r  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_r;
  assign bus.done       = done_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.plot       = in_sweep && (sum_x < (XW+1)'(XSCREEN)) && (sum_y < (YW+1)'(YSCREEN));
  assign bus.vga_x      = in_sweep ? sum_x[XW-1:0] : hold_x;
  assign bus.vga_y      = in_sweep ? sum_y[YW-1:0] : hold_y;
  assign bus.vga_colour = in_sweep ? c_lat : hold_c;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb/tb_vga_draw_scheduler.sv - self-checking bench for vga_draw_scheduler
module tb_vga_draw_scheduler;
  import vga_draw_scheduler_pkg::*;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  vga_draw_scheduler_if bus ();

  vga_draw_scheduler dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  typedef struct {
    int idx; int x; int y; int w; int h; int c;
    int exp_plots; int exp_cyc; int fx; int fy; int lx; int ly;
  } vec_t;

  vec_t vecs[8];
  int n_tests = 0;
  int n_fail  = 0;

  // Background monitor: plot count, done pulse count, order of grants.
  int              mon_plots = 0;
  int              mon_dones = 0;
  int              n_grants  = 0;
  int              grant_log[64];
  logic [NREQ-1:0] prev_grant = '0;

  always @(negedge Clock) begin
    if (bus.plot === 1'b1) mon_plots++;
    for (int i = 0; i < NREQ; i++) if (bus.done[i] === 1'b1) mon_dones++;
    if (bus.grant !== '0 && bus.grant !== 'x && prev_grant === '0) begin
      if (n_grants < 64) grant_log[n_grants] = int'(bus.grant);
      n_grants++;
    end
    prev_grant = bus.grant;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_fields(input int i, input int x, input int y, input int w, input int h, input int c);
    bus.req_x[i*XW +: XW]      = XW'(x);
    bus.req_y[i*YW +: YW]      = YW'(y);
    bus.req_w[i*DW +: DW]      = DW'(w);
    bus.req_h[i*DW +: DW]      = DW'(h);
    bus.req_colour[i*CW +: CW] = CW'(c);
  endtask

  task automatic do_reset();
    Resetn  = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
  endtask

  // One request alone; checks every plotted pixel against a raster model that skips
  // clipped pixels.
  task automatic run_single(input vec_t v, output int cyc, output int plots,
                            output int fx, output int fy, output int lx, output int ly,
                            output int bad);
    int mx;
    int my;
    bit seen;
    mx = 0; my = 0; seen = 1'b0;
    cyc = 0; plots = 0; bad = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    set_fields(v.idx, v.x, v.y, v.w, v.h, v.c);
    bus.req[v.idx] = 1'b1;
    while (!seen && cyc < 400) begin
      @(negedge Clock);
      cyc++;
      if (bus.plot === 1'b1) begin
        while (my < v.h && (v.x + mx >= XSCREEN || v.y + my >= YSCREEN)) begin
          mx++;
          if (mx == v.w) begin mx = 0; my++; end
        end
        if (my >= v.h || int'(bus.vga_x) != v.x + mx || int'(bus.vga_y) != v.y + my ||
            int'(bus.vga_colour) != v.c || int'(bus.grant) != (1 << v.idx))
          bad++;
        if (plots == 0) begin fx = int'(bus.vga_x); fy = int'(bus.vga_y); end
        lx = int'(bus.vga_x);
        ly = int'(bus.vga_y);
        plots++;
        mx++;
        if (mx == v.w) begin mx = 0; my++; end
      end
      if (bus.done !== '0) begin
        seen = 1'b1;
        if (int'(bus.done) != (1 << v.idx)) bad++;
      end
    end
    bus.req[v.idx] = 1'b0;
    if (!seen) cyc = -1;
    @(negedge Clock);
  endtask

  int cyc, plots, fx, fy, lx, ly, bad;
  int g0, p0, d0, k;

  initial begin
    //            idx  x    y    w   h   c  plots cyc  fx   fy   lx   ly
    vecs[0] = '{0,   30,  30,  10, 10, 4, 100, 102, 30,  30,  39,  39};
    vecs[1] = '{2,   155, 115, 10, 10, 1, 25,  102, 155, 115, 159, 119};
    vecs[2] = '{1,   0,   0,   0,  5,  3, 0,   2,   0,   0,   0,   0};
    vecs[3] = '{0,   5,   6,   3,  1,  7, 3,   5,   5,   6,   7,   6};
    vecs[4] = '{1,   159, 119, 1,  1,  2, 1,   3,   159, 119, 159, 119};
    vecs[5] = '{2,   160, 0,   2,  2,  5, 0,   6,   0,   0,   0,   0};
    vecs[6] = '{0,   20,  20,  5,  0,  6, 0,   2,   0,   0,   0,   0};
    vecs[7] = '{1,   250, 10,  15, 15, 1, 0,   227, 0,   0,   0,   0};

    Resetn         = 1'b0;
    bus.req        = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_w      = '0;
    bus.req_h      = '0;
    bus.req_colour = '0;
    repeat (2) @(negedge Clock);
    check("reset_busy",   int'(bus.busy),       0);
    check("reset_grant",  int'(bus.grant),      0);
    check("reset_done",   int'(bus.done),       0);
    check("reset_plot",   int'(bus.plot),       0);
    check("reset_vga_x",  int'(bus.vga_x),      0);
    check("reset_vga_y",  int'(bus.vga_y),      0);
    check("reset_colour", int'(bus.vga_colour), 0);
    Resetn = 1'b1;
    @(negedge Clock);

    for (int n = 0; n < 8; n++) begin
      run_single(vecs[n], cyc, plots, fx, fy, lx, ly, bad);
      check($sformatf("v%0d_done_latency", n), cyc, vecs[n].exp_cyc);
      check($sformatf("v%0d_plots", n), plots, vecs[n].exp_plots);
      check($sformatf("v%0d_bad_pixels", n), bad, 0);
      if (vecs[n].exp_plots > 0) begin
        check($sformatf("v%0d_first_x", n), fx, vecs[n].fx);
        check($sformatf("v%0d_first_y", n), fy, vecs[n].fy);
        check($sformatf("v%0d_last_x", n), lx, vecs[n].lx);
        check($sformatf("v%0d_last_y", n), ly, vecs[n].ly);
      end
      check($sformatf("v%0d_idle_after", n), int'(bus.busy), 0);
    end

    // All three at once, pointer fresh from reset: served 0,1,2.
    do_reset();
    g0 = n_grants; p0 = mon_plots; d0 = mon_dones;
    for (int i = 0; i < NREQ; i++) set_fields(i, 10 + 20*i, 10, 2, 2, i + 1);
    bus.req = '1;
    k = 0;
    while (bus.req != '0 && k < 100) begin
      @(negedge Clock);
      k++;
      for (int i = 0; i < NREQ; i++) if (bus.done[i] === 1'b1) bus.req[i] = 1'b0;
    end
    @(negedge Clock);
    check("rr_all_served", int'(bus.req), 0);
    check("rr_grant_count", n_grants - g0, 3);
    check("rr_grant_1st", grant_log[g0],     1);
    check("rr_grant_2nd", grant_log[g0 + 1], 2);
    check("rr_grant_3rd", grant_log[g0 + 2], 4);
    check("rr_plots", mon_plots - p0, 12);
    check("rr_dones", mon_dones - d0, 3);

    // req1 re-raised right after its done while req2 waits: req2 goes first.
    do_reset();
    g0 = n_grants;
    set_fields(1, 1, 1, 1, 1, 2);
    set_fields(2, 3, 3, 1, 1, 3);
    bus.req = 3'b010;
    k = 0;
    while (bus.grant === '0 && k < 10) begin @(negedge Clock); k++; end
    bus.req[2] = 1'b1;
    k = 0;
    while (bus.done[1] !== 1'b1 && k < 20) begin @(negedge Clock); k++; end
    check("b2b_first_done_seen", int'(bus.done[1] === 1'b1), 1);
    bus.req[1] = 1'b0;
    @(negedge Clock);
    bus.req[1] = 1'b1;
    k = 0;
    while (bus.req != '0 && k < 100) begin
      @(negedge Clock);
      k++;
      for (int i = 0; i < NREQ; i++) if (bus.done[i] === 1'b1) bus.req[i] = 1'b0;
    end
    @(negedge Clock);
    check("b2b_grant_count", n_grants - g0, 3);
    check("b2b_grant_1st", grant_log[g0],     2);
    check("b2b_grant_2nd", grant_log[g0 + 1], 4);
    check("b2b_grant_3rd", grant_log[g0 + 2], 2);

    // Fields scrambled and req dropped after LOAD: sweep completes unchanged.
    p0 = mon_plots; d0 = mon_dones;
    set_fields(0, 40, 50, 3, 2, 5);
    bus.req[0] = 1'b1;
    k = 0;
    while (bus.grant === '0 && k < 10) begin @(negedge Clock); k++; end
    @(negedge Clock);
    check("latch_first_plot", int'(bus.plot), 1);
    check("latch_first_x", int'(bus.vga_x), 40);
    check("latch_first_y", int'(bus.vga_y), 50);
    set_fields(0, 0, 0, 0, 0, 0);
    bus.req[0] = 1'b0;
    k = 0;
    while (bus.done === '0 && k < 20) begin @(negedge Clock); k++; end
    @(negedge Clock);
    check("latch_plots", mon_plots - p0, 6);
    check("latch_dones", mon_dones - d0, 1);
    check("latch_hold_x", int'(bus.vga_x), 42);
    check("latch_hold_y", int'(bus.vga_y), 51);

    // Reset mid-sweep: everything clears, no done pulse afterwards.
    set_fields(0, 60, 60, 10, 10, 6);
    bus.req[0] = 1'b1;
    repeat (20) @(negedge Clock);
    Resetn  = 1'b0;
    bus.req = '0;
    @(negedge Clock);
    check("midrst_busy",   int'(bus.busy),       0);
    check("midrst_grant",  int'(bus.grant),      0);
    check("midrst_done",   int'(bus.done),       0);
    check("midrst_plot",   int'(bus.plot),       0);
    check("midrst_vga_x",  int'(bus.vga_x),      0);
    check("midrst_vga_y",  int'(bus.vga_y),      0);
    check("midrst_colour", int'(bus.vga_colour), 0);
    Resetn = 1'b1;
    p0 = mon_plots; d0 = mon_dones;
    repeat (150) @(negedge Clock);
    check("midrst_no_done", mon_dones - d0, 0);
    check("midrst_no_plot", mon_plots - p0, 0);
    check("midrst_idle", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
